// File: rtl/fifo_merge_pkg.sv
// Shared definitions for the write- and read-side controllers of the dual-clock merge FIFO.
`timescale 1ns/1ps
package fifo_merge_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_ADDR_WIDTH     = 4;
    localparam int unsigned DEF_ALMOST_FULL_TH = 12;

    // Widest pointer the level helper handles; real pointers are zero-extended into it.
    localparam int unsigned PTR_MAX_W = 32;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // Pointer type at the default depth.
    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

    // Fill level = (minuend - subtrahend) modulo 2^pw.
    // The write side calls it as (wptr, rptr_sync) and the read side as (wptr_sync, rptr).
    function automatic logic [PTR_MAX_W-1:0] level_of(input logic [PTR_MAX_W-1:0] wptr,
                                                      input logic [PTR_MAX_W-1:0] rptr,
                                                      input int unsigned          pw);
        logic [PTR_MAX_W-1:0] mask;
        mask = (pw >= PTR_MAX_W) ? '1 : ((PTR_MAX_W'(1) << pw) - PTR_MAX_W'(1));
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_level_calc.sv
// Level and threshold flags from a pair of binary pointers. It is shared with the read side.
`timescale 1ns/1ps
module fifo_level_calc
    import fifo_merge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL_TH = DEF_ALMOST_FULL_TH
) (
    input  logic [ADDR_WIDTH:0] wptr,
    input  logic [ADDR_WIDTH:0] rptr,
    output logic [ADDR_WIDTH:0] level,
    output logic                at_depth,
    output logic                over_depth,
    output logic                above_th
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Modular difference. The natural wrap of either pointer needs no special handling.
    always_comb begin
        level      = PW'(level_of(PTR_MAX_W'(wptr), PTR_MAX_W'(rptr), PW));
        at_depth   = (level == PW'(DEPTH));
        over_depth = (level >  PW'(DEPTH));
        above_th   = (level >= PW'(ALMOST_FULL_TH));
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock merge FIFO.
// It runs the valid/ready handshake, drives the RAM write port, owns the binary write pointer,
// and tracks level, peak and pointer-error status against the synchronized read pointer.
`timescale 1ns/1ps
module fifo_wr_ctrl
    import fifo_merge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL_TH = DEF_ALMOST_FULL_TH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [ADDR_WIDTH:0]   wptr_bin_o,
    input  logic [ADDR_WIDTH:0]   rptr_sync_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic [ADDR_WIDTH:0]   peak_level_o,
    output logic                  ptr_err_o
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] wptr_q;
    logic [ADDR_WIDTH:0] peak_q;
    logic                err_q;
    logic                over_depth;
    logic                fire;

    fifo_level_calc #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .ALMOST_FULL_TH (ALMOST_FULL_TH)
    ) u_level (
        .wptr       (wptr_q),
        .rptr       (rptr_sync_i),
        .level      (level_o),
        .at_depth   (full_o),
        .over_depth (over_depth),
        .above_th   (almost_full_o)
    );

    // Ready does not depend on wr_valid_i. The RAM commits on the same edge that advances the pointer.
    always_comb begin
        wr_ready_o   = ~full_o & ~err_q & rst_ni;
        fire         = wr_valid_i & wr_ready_o;
        mem_we_o     = fire;
        mem_waddr_o  = wptr_q[ADDR_WIDTH-1:0];
        mem_wdata_o  = wr_data_i;
        wptr_bin_o   = wptr_q;
        peak_level_o = peak_q;
        ptr_err_o    = err_q;
    end

    // Pointer advance, peak capture and the sticky pointer-error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            peak_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (fire) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (level_o > peak_q) begin
                peak_q <= level_o;
            end
            if (over_depth) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
